// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths and the queue entry type for the register-file
// writeback buffer.
//   REG_ADDR_W / REG_DATA_W : register address and data widths
//   REG_ZERO                : hard-wired zero register (never written)
//   wb_entry_t              : one pending write {addr, data}
package rf_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: in-order storage for pending register writes.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   push           : append wr_entry at tail
//   ovr            : overwrite data of the youngest entry (slot tail-1)
//   pop            : retire head entry (caller guarantees count != 0)
//   wr_entry       : entry being written
//   head_entry     : oldest valid entry
//   entries        : raw storage, indexed by physical slot
//   valid          : per-slot valid flags, so the caller can search by age
//   head_ptr       : physical slot of the oldest entry
//   count          : occupancy
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         ovr,
  input  logic                         pop,
  input  wb_entry_t                    wr_entry,
  output wb_entry_t                    head_entry,
  output wb_entry_t [DEPTH-1:0]        entries,
  output logic      [DEPTH-1:0]        valid,
  output logic      [PTR_W-1:0]        head_ptr,
  output logic      [CNT_W-1:0]        count
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, yng_ptr;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  assign yng_ptr = tail_q - PTR_W'(1);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = wr_entry;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (ovr) mem_d[yng_ptr].data = wr_entry.data;
    if (pop) head_d = head_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A slot is valid when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    off   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - head_q;
      valid[i] = CNT_W'(off) < count_q;
    end
  end

  assign head_entry = mem_q[head_q];
  assign entries    = mem_q;
  assign head_ptr   = head_q;
  assign count      = count_q;

endmodule

// File: rtl/rf_writeback_buffer.sv
// rf_writeback_buffer: queues execute/memory results and drives the 32x32
// register-file write port (D / D_En / D_Addr) at one write per cycle, with
// forwarding lookups on two read addresses.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   wb_valid/ready/addr/data : producer handshake (addr 0 is accepted, dropped)
//   drain_en              : register-file port free this cycle
//   D, D_En, D_Addr       : registered write port
//   S_Addr/S_hit/S_fwd    : forwarding lookup S
//   T_Addr/T_hit/T_fwd    : forwarding lookup T
//   count                 : queue occupancy
// Build option: RF_WB_COALESCE_EN merges a write into the youngest queued
// entry when the addresses match (also accepted while full).
module rf_writeback_buffer
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_DATA_W-1:0] wb_data,
  input  logic                  drain_en,
  output logic [REG_DATA_W-1:0] D,
  output logic                  D_En,
  output logic [REG_ADDR_W-1:0] D_Addr,
  input  logic [REG_ADDR_W-1:0] S_Addr,
  input  logic [REG_ADDR_W-1:0] T_Addr,
  output logic                  S_hit,
  output logic [REG_DATA_W-1:0] S_fwd,
  output logic                  T_hit,
  output logic [REG_DATA_W-1:0] T_fwd,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t                    head_entry;
  wb_entry_t [DEPTH-1:0]        entries;
  logic      [DEPTH-1:0]        valid;
  logic      [PTR_W-1:0]        head_ptr;
  logic full, drain, nonzero, coal_match, accept, push, ovr;

  assign full    = (count == CNT_W'(DEPTH));
  assign drain   = drain_en && (count != '0);
  assign nonzero = (wb_addr != REG_ZERO);

`ifdef RF_WB_COALESCE_EN
  logic [PTR_W-1:0] yng_idx;
  assign yng_idx = head_ptr + PTR_W'(count - CNT_W'(1));
  // A sole entry leaving this cycle is not merged into; the write enqueues.
  assign coal_match = nonzero && (count != '0) &&
                      (entries[yng_idx].addr == wb_addr) &&
                      !(drain && (count == CNT_W'(1)));
  assign wb_ready   = !full || coal_match;
`else
  assign coal_match = 1'b0;
  assign wb_ready   = !full;
`endif

  assign accept = wb_valid && wb_ready;
  assign push   = accept && nonzero && !coal_match;
  assign ovr    = accept && coal_match;

  rf_wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .ovr        (ovr),
    .pop        (drain),
    .wr_entry   ('{addr: wb_addr, data: wb_data}),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid),
    .head_ptr   (head_ptr),
    .count      (count)
  );

  // Output stage: D / D_Addr hold when idle, D_En pulses per write.
  logic [REG_DATA_W-1:0] d_q, d_d;
  logic [REG_ADDR_W-1:0] d_addr_q, d_addr_d;
  logic                  d_en_q, d_en_d;

  always_comb begin
    d_d      = d_q;
    d_addr_d = d_addr_q;
    d_en_d   = 1'b0;
    if (drain) begin
      d_d      = head_entry.data;
      d_addr_d = head_entry.addr;
      d_en_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q      <= '0;
      d_addr_q <= '0;
      d_en_q   <= 1'b0;
    end else begin
      d_q      <= d_d;
      d_addr_q <= d_addr_d;
      d_en_q   <= d_en_d;
    end
  end

  assign D      = d_q;
  assign D_Addr = d_addr_q;
  assign D_En   = d_en_q;

  // Forwarding: the output stage is the oldest candidate; queue slots are
  // scanned oldest to youngest so the youngest match ends up winning.
  logic [1:0][REG_ADDR_W-1:0] lk_addr;
  logic [1:0]                 lk_hit;
  logic [1:0][REG_DATA_W-1:0] lk_data;

  assign lk_addr = {T_Addr, S_Addr};

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    lk_hit  = '0;
    lk_data = '0;
    for (int j = 0; j < 2; j++) begin
      lk_hit[j]  = d_en_q && (d_addr_q == lk_addr[j]);
      lk_data[j] = d_q;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + PTR_W'(k);
        if (valid[idx] && (entries[idx].addr == lk_addr[j])) begin
          lk_hit[j]  = 1'b1;
          lk_data[j] = entries[idx].data;
        end
      end
      if (lk_addr[j] == REG_ZERO) lk_hit[j] = 1'b0;
    end
  end

  assign S_hit = lk_hit[0];
  assign S_fwd = lk_data[0];
  assign T_hit = lk_hit[1];
  assign T_fwd = lk_data[1];

endmodule

// File: tb/tb_rf_writeback_buffer.sv
module tb_rf_writeback_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ready, drain_en, D_En, S_hit, T_hit;
  logic [4:0]  wb_addr, D_Addr, S_Addr, T_Addr;
  logic [31:0] wb_data, D, S_fwd, T_fwd;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_writeback_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .drain_en(drain_en),
    .D(D), .D_En(D_En), .D_Addr(D_Addr), .S_Addr(S_Addr), .T_Addr(T_Addr),
    .S_hit(S_hit), .S_fwd(S_fwd), .T_hit(T_hit), .T_fwd(T_fwd), .count(count)
  );

  // Reference model: a queue of pending writes plus the output stage.
  typedef struct { logic [4:0] a; logic [31:0] d; } m_t;
  m_t          mq[$];
  logic [31:0] m_d;
  logic [4:0]  m_da;
  logic        m_den;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_d = '0; m_da = '0; m_den = 1'b0;
  endtask

  function automatic logic m_coal(input logic [4:0] a, input logic dr);
`ifdef RF_WB_COALESCE_EN
    if (a == 0 || mq.size() == 0) return 1'b0;
    return (mq[$].a == a) && !(dr && mq.size() == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_ready(input logic [4:0] a, input logic dr);
    return (mq.size() != DEPTH) || m_coal(a, dr);
  endfunction

  // Youngest pending write wins; the output stage is the last resort.
  task automatic m_fwd(input logic [4:0] a, output logic hit, output logic [31:0] data);
    hit = 1'b0; data = '0;
    if (a == 0) return;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) begin hit = 1'b1; data = mq[i].d; return; end
    if (m_den && m_da == a) begin hit = 1'b1; data = m_d; end
  endtask

  task automatic m_edge(input logic v, input logic [4:0] a, input logic [31:0] d, input logic dr);
    logic cm, acc, do_drain;
    m_t e;
    do_drain = dr && (mq.size() != 0);
    cm  = m_coal(a, dr);
    acc = v && m_ready(a, dr);
    if (do_drain) begin
      e = mq.pop_front();
      m_d = e.d; m_da = e.a; m_den = 1'b1;
    end else m_den = 1'b0;
    if (acc && a != 0) begin
      if (cm) mq[$].d = d;
      else begin e.a = a; e.d = d; mq.push_back(e); end
    end
  endtask

  task automatic check_all();
    logic h; logic [31:0] f;
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, m_ready(wb_addr, drain_en)});
    chk("count", {29'd0, count}, mq.size());
    chk("D_En", {31'd0, D_En}, {31'd0, m_den});
    chk("D_Addr", {27'd0, D_Addr}, {27'd0, m_da});
    chk("D", D, m_d);
    m_fwd(S_Addr, h, f);
    chk("S_hit", {31'd0, S_hit}, {31'd0, h});
    if (h) chk("S_fwd", S_fwd, f);
    m_fwd(T_Addr, h, f);
    chk("T_hit", {31'd0, T_hit}, {31'd0, h});
    if (h) chk("T_fwd", T_fwd, f);
  endtask

  // One clock: drive, check combinational view before the edge, then advance.
  task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic dr, input logic [4:0] s, input logic [4:0] t);
    wb_valid = v; wb_addr = a; wb_data = d; drain_en = dr; S_Addr = s; T_Addr = t;
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_edge(v, a, d, dr);
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 0; wb_addr = 0; wb_data = 0; drain_en = 0;
    S_Addr = 5'd5; T_Addr = 5'd9;
    m_reset();
    #12;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);
    chk("rst_D_En", {31'd0, D_En}, 32'd0);
    chk("rst_D", D, 32'd0);
    chk("rst_D_Addr", {27'd0, D_Addr}, 32'd0);
    chk("rst_S_hit", {31'd0, S_hit}, 32'd0);
    chk("rst_T_hit", {31'd0, T_hit}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Single write, drain enabled: D_En one cycle after the handshake.
    cycle(1, 5'd5, 32'hDEADBEEF, 1, 0, 0);
    chk("t1_D_En_early", {31'd0, D_En}, 32'd0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("t1_D_En", {31'd0, D_En}, 32'd1);
    chk("t1_D_Addr", {27'd0, D_Addr}, 32'd5);
    chk("t1_D", D, 32'hDEADBEEF);
    chk("t1_count", {29'd0, count}, 32'd0);

    // Fill, stall, drain in order.
    for (int k = 1; k <= 4; k++) cycle(1, 5'(k), 32'h100 + k, 0, 0, 0);
    chk("t2_count", {29'd0, count}, 32'd4);
    chk("t2_ready", {31'd0, wb_ready}, 32'd0);
    cycle(1, 5'd5, 32'h105, 0, 0, 0);
    chk("t2_stall", {29'd0, count}, 32'd4);
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 0, 1, 0, 0);
      chk("t2_D_Addr", {27'd0, D_Addr}, k);
    end
    cycle(0, 0, 0, 1, 0, 0);

    // Register 0: handshake but nothing queued.
    cycle(1, 5'd0, 32'h1234, 1, 0, 0);
    chk("t3_count", {29'd0, count}, 32'd0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("t3_D_En", {31'd0, D_En}, 32'd0);
    chk("t3_S_hit", {31'd0, S_hit}, 32'd0);

    // Duplicate addresses: youngest value forwarded.
    cycle(1, 5'd7, 32'hA, 0, 7, 0);
    cycle(1, 5'd7, 32'hB, 0, 7, 0);
    chk("t4_S_hit", {31'd0, S_hit}, 32'd1);
    chk("t4_S_fwd", S_fwd, 32'hB);
    cycle(0, 0, 0, 1, 7, 0);
    chk("t4_S_fwd_drain", S_fwd, 32'hB);
    cycle(0, 0, 0, 1, 7, 0);
    cycle(0, 0, 0, 0, 7, 0);
    chk("t4_S_hit_end", {31'd0, S_hit}, 32'd0);

    // T forwarding from the output stage.
    cycle(1, 5'd9, 32'h55, 1, 0, 9);
    cycle(0, 0, 0, 1, 0, 9);
    chk("t5_T_hit", {31'd0, T_hit}, 32'd1);
    chk("t5_T_fwd", T_fwd, 32'h55);
    cycle(0, 0, 0, 0, 0, 9);

    // Randomized traffic with a small address range to force collisions.
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    for (int n = 0; n < DEPTH + 2; n++) cycle(0, 0, 0, 1, 0, 0);

    // Reset mid-operation: 3 queued, output stage active.
    for (int k = 1; k <= 4; k++) cycle(1, 5'(k + 10), 32'h200 + k, 0, 0, 0);
    cycle(0, 0, 0, 1, 5'd12, 0);
    chk("t6_pre_D_En", {31'd0, D_En}, 32'd1);
    chk("t6_pre_count", {29'd0, count}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_D_En", {31'd0, D_En}, 32'd0);
    chk("t6_D", D, 32'd0);
    chk("t6_D_Addr", {27'd0, D_Addr}, 32'd0);
    chk("t6_count", {29'd0, count}, 32'd0);
    chk("t6_ready", {31'd0, wb_ready}, 32'd1);
    chk("t6_S_hit", {31'd0, S_hit}, 32'd0);
    m_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

`ifdef RF_WB_COALESCE_EN
    // Full queue, youngest is reg 6: merge accepted without growing.
    cycle(1, 5'd1, 32'h1, 0, 0, 0);
    cycle(1, 5'd2, 32'h2, 0, 0, 0);
    cycle(1, 5'd3, 32'h3, 0, 0, 0);
    cycle(1, 5'd6, 32'h6, 0, 6, 0);
    chk("t7_full", {29'd0, count}, DEPTH);
    wb_addr = 5'd6; #1;
    chk("t7_ready", {31'd0, wb_ready}, 32'd1);
    cycle(1, 5'd6, 32'h77, 0, 6, 0);
    chk("t7_count", {29'd0, count}, DEPTH);
    chk("t7_S_fwd", S_fwd, 32'h77);
    for (int k = 0; k < DEPTH; k++) cycle(0, 0, 0, 1, 0, 0);
    chk("t7_D_Addr", {27'd0, D_Addr}, 32'd6);
    chk("t7_D", D, 32'h77);
`endif
    cycle(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
